// File: rtl/keypad_entry_buffer_pkg.sv
// Shared constants and state type for the keypad entry buffer.
// Key codes, display nibble glyphs and the entry FSM states.
package keypad_entry_buffer_pkg;

   localparam logic [3:0] KEY_STAR  = 4'd10;
   localparam logic [3:0] KEY_HASH  = 4'd11;

   localparam logic [3:0] NIB_BLANK = 4'hF;
   localparam logic [3:0] NIB_MASK  = 4'hA;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ENTRY   = 2'd1,
      ST_CONVERT = 2'd2,
      ST_HOLD    = 2'd3
   } state_e;

endpackage

// File: rtl/keypad_entry_buffer_bcd_serial_to_bin.sv
// Serial BCD-to-binary converter: acc = acc*10 + nibble, MSB nibble first.
// Ports: clk, rst (sync, active high), start_i, nibble_i in;
//        nib_idx_o (nibble to feed next), acc_o, done_o out.
module bcd_serial_to_bin
   import keypad_entry_buffer_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int VAL_W  = 14,
   parameter int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [3:0]       nibble_i,
   output logic [IW-1:0]    nib_idx_o,
   output logic [VAL_W-1:0] acc_o,
   output logic             done_o
);

   logic             run_q;
   logic [IW-1:0]    cnt_q;
   logic [VAL_W-1:0] acc_q;
   logic [VAL_W-1:0] acc_d;

   // x10 as x8 + x2; wraps silently if VAL_W is undersized.
   assign acc_d = (acc_q << 3)
                + (acc_q << 1)
                + VAL_W'(nibble_i);

   assign nib_idx_o = IW'(DIGITS - 1) - cnt_q;
   assign done_o    = run_q
                   && (cnt_q == IW'(DIGITS - 1));
   assign acc_o     = acc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         run_q <= 1'b0;
         cnt_q <= '0;
         acc_q <= '0;
      end else if (start_i) begin
         run_q <= 1'b1;
         cnt_q <= '0;
         acc_q <= '0;
      end else if (run_q) begin
         acc_q <= acc_d;
         if (done_o) begin
            run_q <= 1'b0;
         end else begin
            cnt_q <= cnt_q + IW'(1);
         end
      end
   end

endmodule

// File: rtl/keypad_entry_buffer.sv
// Keypad entry buffer: assembles decimal entries, drives FND, commits binary.
// Ports: clk, rst, key_value/key_valid in; disp_bcd, digit_count out;
//        entry_value/entry_valid out, entry_ready in; busy, overflow,
//        timeout out. Macro KEYPAD_PIN_MASK_EN shows dashes for digits.
module keypad_entry_buffer
   import keypad_entry_buffer_pkg::*;
#(
   parameter int          DIGITS      = 4,
   parameter int          VAL_W       = 14,
   parameter int unsigned TIMEOUT_CYC = 250000000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [3:0]                    key_value,
   input  logic                          key_valid,
   output logic [4*DIGITS-1:0]           disp_bcd,
   output logic [$clog2(DIGITS+1)-1:0]   digit_count,
   output logic [VAL_W-1:0]              entry_value,
   output logic                          entry_valid,
   input  logic                          entry_ready,
   output logic                          busy,
   output logic                          overflow,
   output logic                          timeout
);

   localparam int DW = 4 * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int TW = (TIMEOUT_CYC < 2)
                     ? 1 : $clog2(TIMEOUT_CYC + 1);

   state_e         state_q, state_d;
   logic [DW-1:0]  dig_q, dig_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [TW-1:0]  tmo_q, tmo_d;
   logic           ovf_q, ovf_d;
   logic           tout_q, tout_d;

   logic           is_digit;
   logic           tmo_fire;
   logic           conv_start;
   logic           conv_done;
   logic [IW-1:0]  conv_idx;
   logic [3:0]     conv_nib;
   logic [3:0]     nib [DIGITS];

   assign is_digit = (key_value < 4'd10);

   // Fires on the TIMEOUT_CYC-th consecutive idle cycle in ENTRY.
   assign tmo_fire = (TIMEOUT_CYC != 0)
                  && (tmo_q == TW'(TIMEOUT_CYC - 1));

   assign conv_nib = nib[conv_idx];

   for (genvar i = 0; i < DIGITS; i++) begin : g_disp
      logic occ;
      assign occ    = (CW'(i) < cnt_q);
      assign nib[i] = dig_q[4*i +: 4];
`ifdef KEYPAD_PIN_MASK_EN
      assign disp_bcd[4*i +: 4] = occ ? NIB_MASK
                                      : NIB_BLANK;
`else
      assign disp_bcd[4*i +: 4] = occ ? nib[i]
                                      : NIB_BLANK;
`endif
   end

   always_comb begin
      state_d    = state_q;
      dig_d      = dig_q;
      cnt_d      = cnt_q;
      tmo_d      = '0;
      ovf_d      = 1'b0;
      tout_d     = 1'b0;
      conv_start = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (key_valid && is_digit) begin
               dig_d   = DW'(key_value);
               cnt_d   = CW'(1);
               state_d = ST_ENTRY;
            end
         end
         ST_ENTRY: begin
            if (key_valid) begin
               if (is_digit) begin
                  if (cnt_q < CW'(DIGITS)) begin
                     dig_d = (dig_q << 4)
                           | DW'(key_value);
                     cnt_d = cnt_q + CW'(1);
                  end else begin
                     ovf_d = 1'b1;
                  end
               end else if (key_value == KEY_STAR) begin
                  // Vacated top nibble shifts in as zero.
                  dig_d = dig_q >> 4;
                  cnt_d = cnt_q - CW'(1);
                  if (cnt_q == CW'(1)) begin
                     state_d = ST_IDLE;
                  end
               end else if (key_value == KEY_HASH) begin
                  conv_start = 1'b1;
                  state_d    = ST_CONVERT;
               end
            end else if (tmo_fire) begin
               dig_d   = '0;
               cnt_d   = '0;
               tout_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         ST_CONVERT: begin
            if (conv_done) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (entry_ready) begin
               dig_d   = '0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         dig_q   <= '0;
         cnt_q   <= '0;
         tmo_q   <= '0;
         ovf_q   <= 1'b0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dig_q   <= dig_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         ovf_q   <= ovf_d;
         tout_q  <= tout_d;
      end
   end

   bcd_serial_to_bin #(
      .DIGITS (DIGITS),
      .VAL_W  (VAL_W),
      .IW     (IW)
   ) u_conv (
      .clk       (clk),
      .rst       (rst),
      .start_i   (conv_start),
      .nibble_i  (conv_nib),
      .nib_idx_o (conv_idx),
      .acc_o     (entry_value),
      .done_o    (conv_done)
   );

   assign digit_count = cnt_q;
   assign entry_valid = (state_q == ST_HOLD);
   assign busy        = (state_q == ST_CONVERT)
                     || (state_q == ST_HOLD);
   assign overflow    = ovf_q;
   assign timeout     = tout_q;

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Bench for keypad_entry_buffer: directed plan then random keys,
// compared every cycle against a queue-based entry model.
module tb_keypad_entry_buffer;

   localparam int          DIGITS = 4;
   localparam int          VAL_W  = 14;
   localparam int unsigned TMO    = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  key_value;
   logic        key_valid;
   logic [15:0] disp_bcd;
   logic [2:0]  digit_count;
   logic [13:0] entry_value;
   logic        entry_valid;
   logic        entry_ready;
   logic        busy;
   logic        overflow;
   logic        timeout;

   keypad_entry_buffer #(
      .DIGITS      (DIGITS),
      .VAL_W       (VAL_W),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_value   (key_value),
      .key_valid   (key_valid),
      .disp_bcd    (disp_bcd),
      .digit_count (digit_count),
      .entry_value (entry_value),
      .entry_valid (entry_valid),
      .entry_ready (entry_ready),
      .busy        (busy),
      .overflow    (overflow),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   int total  = 0;
   int passed = 0;

   // Reference model: digits typed so far (leftmost first), plus
   // a conversion countdown and a committed value.
   int mq[$];
   int conv_left = 0;
   bit hold      = 0;
   int mval      = 0;
   int idle      = 0;
   bit e_ovf     = 0;
   bit e_tout    = 0;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h",
                  tag, obs, exp);
   endtask

   function automatic int mq_value();
      int v = 0;
      foreach (mq[i]) v = v * 10 + mq[i];
      return v;
   endfunction

   function automatic logic [15:0] exp_disp();
      logic [15:0] d = 16'hFFFF;
      int n = mq.size();
      for (int i = 0; i < n; i++) begin
`ifdef KEYPAD_PIN_MASK_EN
         d[4*i +: 4] = 4'hA;
`else
         d[4*i +: 4] = 4'(mq[n-1-i]);
`endif
      end
      return d;
   endfunction

   task automatic model(input bit r, input int kv,
                        input bit kval, input bit rdy);
      e_ovf  = 0;
      e_tout = 0;
      if (r) begin
         mq.delete();
         conv_left = 0;
         hold = 0;
         idle = 0;
         mval = 0;
      end else if (conv_left > 0) begin
         conv_left--;
         if (conv_left == 0) hold = 1;
      end else if (hold) begin
         if (rdy) begin
            hold = 0;
            mq.delete();
         end
      end else if (mq.size() == 0) begin
         if (kval && kv < 10) begin
            mq.push_back(kv);
            idle = 0;
         end
      end else if (kval) begin
         idle = 0;
         if (kv < 10) begin
            if (mq.size() < DIGITS) mq.push_back(kv);
            else e_ovf = 1;
         end else if (kv == 10) begin
            void'(mq.pop_back());
         end else if (kv == 11) begin
            conv_left = DIGITS;
            mval = mq_value();
         end
      end else begin
         idle++;
         if (idle == TMO) begin
            mq.delete();
            idle = 0;
            e_tout = 1;
         end
      end
   endtask

   task automatic check_all();
      chk("disp", 32'(disp_bcd), 32'(exp_disp()));
      chk("count", 32'(digit_count), 32'(mq.size()));
      chk("valid", 32'(entry_valid), 32'(hold));
      chk("busy", 32'(busy), 32'(hold || conv_left > 0));
      chk("ovf", 32'(overflow), 32'(e_ovf));
      chk("tout", 32'(timeout), 32'(e_tout));
      if (hold) chk("value", 32'(entry_value), 32'(mval));
   endtask

   task automatic tick(input bit r, input int kv,
                       input bit kval, input bit rdy);
      rst         = r;
      key_value   = 4'(kv);
      key_valid   = kval;
      entry_ready = rdy;
      @(posedge clk);
      model(r, kv, kval, rdy);
      #1;
      check_all();
   endtask

   task automatic key(input int kv);
      tick(0, kv, 1, 0);
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
   endtask

   initial begin
      rst = 1; key_value = 0; key_valid = 0; entry_ready = 0;
      tick(1, 0, 0, 0);
      tick(1, 5, 1, 1);
      chk("rst_value", 32'(entry_value), 32'd0);

      key(1); key(2); key(3);
`ifndef KEYPAD_PIN_MASK_EN
      chk("disp_123", 32'(disp_bcd), 32'h0000F123);
`else
      chk("disp_mask", 32'(disp_bcd), 32'h0000FAAA);
`endif
      key(11);
      idle_n(3);
      chk("not_yet", 32'(entry_valid), 32'd0);
      idle_n(1);
      chk("v123", 32'(entry_valid), 32'd1);
      chk("e123", 32'(entry_value), 32'd123);
      tick(0, 0, 0, 1);
      chk("acc_v", 32'(entry_valid), 32'd0);
      chk("acc_d", 32'(disp_bcd), 32'h0000FFFF);

      key(10); key(11); key(13);
      chk("idle_ign", 32'(digit_count), 32'd0);
      key(1); key(2); key(10); key(5); key(11);
      idle_n(4);
      chk("e15", 32'(entry_value), 32'd15);
      tick(0, 0, 0, 1);

      key(9); key(8); key(7); key(6); key(5);
      chk("ovf_pulse", 32'(overflow), 32'd1);
      key(11);
      idle_n(4);
      chk("e9876", 32'(entry_value), 32'd9876);
      tick(0, 0, 0, 1);

      key(4); key(2);
      idle_n(98);
      key(12);
      idle_n(99);
      chk("no_tout", 32'(digit_count), 32'd2);
      idle_n(1);
      chk("tout", 32'(timeout), 32'd1);
      key(4); key(2);
      idle_n(100);
      chk("tout_d", 32'(disp_bcd), 32'h0000FFFF);

      key(7); key(11);
      idle_n(4);
      for (int i = 0; i < 20; i++) tick(0, 3, 1, 0);
      chk("hold7", 32'(entry_value), 32'd7);
      tick(0, 3, 1, 1);
      idle_n(1);
      chk("drop3", 32'(digit_count), 32'd0);

      key(1); key(2); key(11);
      idle_n(1);
      tick(1, 0, 0, 0);
      chk("rst_busy", 32'(busy), 32'd0);
      idle_n(10);

`ifdef KEYPAD_PIN_MASK_EN
      key(1); key(2);
      chk("pin", 32'(disp_bcd), 32'h0000FFAA);
      key(10); key(10);
`endif

      for (int n = 0; n < 4000; n++) begin
         int r = int'($urandom_range(0, 19));
         int kv = (r < 10) ? r
                : (r < 13) ? 10
                : (r < 16) ? 11
                : 12 + (r - 16);
         bit kval = ($urandom_range(0, 9) < 4);
         bit rdy  = ($urandom_range(0, 9) < 3);
         bit rr   = ($urandom_range(0, 599) == 0);
         if ($urandom_range(0, 299) == 0) idle_n(105);
         tick(rr, kv, kval, rdy);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/keypad_entry_buffer.md
Name: keypad_entry_buffer

Overview:
- Consumes the keypad driver's event stream: a 4-bit code plus a one-cycle valid pulse. Codes 0-9 are digits, 10 is `*` and 11 is `#`.
- Assembles a multi-digit decimal entry with backspace, commit and an inactivity timeout.
- Drives the FND digit display directly.
- Delivers the committed entry as a binary value over a valid/ready handshake to the application FSM (lock, calculator, timer set).

Parameters:
- DIGITS, 4: maximum number of digits in one entry (1..8).
- VAL_W, 14: width of entry_value. Must satisfy 10^DIGITS-1 < 2^VAL_W.
- TIMEOUT_CYC, 250000000: number of idle cycles in ENTRY before auto-clear (5 s at 50 MHz). 0 disables the timeout.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- key_value  in  4  key code from the keypad driver.
- key_valid  in  1  one-cycle key event strobe.
- disp_bcd  out  4*DIGITS  display nibbles. Nibble 0 is the rightmost digit. 4'hF means blank.
- digit_count  out  $clog2(DIGITS+1)  number of digits currently entered.
- entry_value  out  VAL_W  committed binary value; meaningful only while entry_valid is high.
- entry_valid  out  1  committed entry available; held high until accepted.
- entry_ready  in  1  consumer accept.
- busy  out  1  high in CONVERT and HOLD; key events are dropped while busy.
- overflow  out  1  one-cycle pulse when a digit is rejected because the buffer is full.
- timeout  out  1  one-cycle pulse on auto-clear.

Behaviour:
- Reset values:
  - state IDLE.
  - digit_count 0; disp_bcd all 4'hF.
  - entry_value 0.
  - entry_valid, busy, overflow and timeout all 0.
  - Timeout counter 0.
- Reset takes priority over every other event in the same cycle, including a reset in the middle of CONVERT or HOLD.
- States: IDLE, ENTRY, CONVERT, HOLD.
- Digit storage:
  - Digits are kept right-aligned in a BCD shift register.
  - A new digit shifts in at nibble 0; older digits move one position left.
  - Unoccupied nibbles read 4'hF on disp_bcd and are treated as 0 internally.
- IDLE:
  - A digit key stores the digit, sets digit_count to 1 and moves to ENTRY.
  - `*`, `#` and codes 12-15 are ignored.
- ENTRY, digit key:
  - If digit_count < DIGITS: shift the digit in and increment digit_count.
  - Otherwise: discard the digit and pulse overflow in the cycle after the key.
- ENTRY, `*` (backspace):
  - Shift right by one nibble, blank the top occupied nibble, decrement digit_count.
  - If digit_count reaches 0, return to IDLE.
- ENTRY, `#`:
  - Move to CONVERT; busy asserts the next cycle.
  - digit_count > 0 always holds in ENTRY.
- ENTRY, codes 12-15: ignored, but still restart the timeout counter.
- Timeout:
  - The counter runs only in ENTRY and clears on every key_valid.
  - On reaching TIMEOUT_CYC consecutive idle cycles: clear the buffer, set digit_count to 0, pulse timeout, go to IDLE.
  - When TIMEOUT_CYC == 0, the counter never fires.
- CONVERT:
  - Serial BCD-to-binary conversion: acc = acc*10 + nibble, one nibble per cycle, MSB nibble first.
  - Exactly DIGITS cycles; leading zero slots are harmless.
  - Key events are dropped.
- HOLD:
  - entry_valid = 1 and entry_value is stable.
  - The display keeps showing the digits.
  - Keys are dropped.
  - On entry_valid && entry_ready: clear the buffer, set digit_count to 0, deassert entry_valid and busy the next cycle, go to IDLE.
  - A key_valid in the same cycle as acceptance is dropped.
- Latency:
  - `#` sampled at cycle T gives CONVERT in T+1..T+DIGITS and entry_valid high from T+DIGITS+1.
  - A digit or backspace at T is visible on disp_bcd and digit_count at T+1.

Optional Feature:
- Macro: KEYPAD_PIN_MASK_EN.
- Defined: occupied nibbles of disp_bcd show 4'hA (dash glyph) instead of the digit, for PIN entry. Blanks, entry_value and all timing are unchanged.
- Undefined: occupied nibbles show the actual digits.

Decomposition:
- Shared package contents:
  - Key code constants: KEY_STAR = 4'd10, KEY_HASH = 4'd11.
  - Display nibble constants: NIB_BLANK = 4'hF, NIB_MASK = 4'hA.
  - The state enum: IDLE, ENTRY, CONVERT, HOLD.
- One sub-module, bcd_serial_to_bin:
  - Inputs: start, nibble stream. Output: acc with a done flag.
  - Implements the multiply-by-10 accumulator, built as (acc<<3)+(acc<<1)+nibble, truncated to VAL_W.

Test Plan (DIGITS=4, TIMEOUT_CYC=100):
- Keys 1,2,3,`#` with ready low → disp_bcd 16'hF123, then entry_valid at T+5 with entry_value 123. Raise ready → next cycle entry_valid 0, digit_count 0, disp_bcd 16'hFFFF.
- Keys 1,2,`*`,5,`#` → entry_value 15. `*` in IDLE and `#` with an empty buffer produce no state change; code 13 is ignored.
- Keys 9,8,7,6,5,`#` → overflow pulse after the fifth key, entry_value 9876.
- Keys 4,2, then 100 idle cycles → timeout pulse, digit_count 0, disp_bcd 16'hFFFF. A key at cycle 99 restarts the count and no timeout fires.
- Commit 7, hold ready low for 20 cycles while sending key 3 → entry_valid stays 1, entry_value stays 7, key 3 is dropped. Ready high in the same cycle as key_valid → key dropped, IDLE.
- rst asserted during CONVERT → all outputs at reset values the next cycle, with no entry_valid afterwards. With KEYPAD_PIN_MASK_EN, keys 1,2 → disp_bcd 16'hFFAA.
